// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller datapath units.
package pid_pkg;

    localparam int unsigned PID_EW = 8;
    localparam int unsigned PID_KW = 6;
    localparam int unsigned PID_OW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SAT  = 2'd2
    } pid_state_e;

    // Signed clamp of a 64-bit value into an ow-bit signed range; sat flags a clamp.
    function automatic logic signed [63:0] sat_clamp(
        input  logic signed [63:0] x,
        input  int unsigned        ow,
        output logic               sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        sat = 1'b0;
        sat_clamp = x;
        if (x > hi) begin
            sat_clamp = hi;
            sat = 1'b1;
        end else if (x < lo) begin
            sat_clamp = lo;
            sat = 1'b1;
        end
    endfunction

endpackage

// File: rtl/pid_derivative_seq_mul.sv
// Sequential shift-add multiplier: signed multiplicand x unsigned multiplier, LSB first.
module seq_shift_add_mul
    import pid_pkg::*;
#(
    parameter int unsigned AW = PID_EW + 1,
    parameter int unsigned BW = PID_KW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena_i,
    input  logic                     abort_i,
    input  logic                     start_i,
    input  logic signed [AW-1:0]     a_i,
    input  logic [BW-1:0]            b_i,
    output logic signed [AW+BW-1:0]  acc_o,
    output logic                     last_c
);

    localparam int unsigned PW = AW + BW;
    localparam int unsigned CW = $clog2(BW + 1);

    logic signed [AW-1:0] a_q, a_d;
    logic [BW-1:0]        b_q, b_d;
    logic signed [PW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    assign last_c = busy_q && (cnt_q == CW'(BW - 1));
    assign acc_o  = acc_q;

    // Load on start, then add one shifted partial product per enabled cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (ena_i) begin
            if (abort_i) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else if (start_i) begin
                a_d    = a_i;
                b_d    = b_i;
                acc_d  = '0;
                cnt_d  = '0;
                busy_d = 1'b1;
            end else if (busy_q) begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + (PW'(a_q) <<< cnt_q);
                end
                if (last_c) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/pid_derivative_seq.sv
// Derivative term: K_d * (e[n] - e[n-1]), fixed-point scaled and saturated.
module pid_derivative_seq
    import pid_pkg::*;
#(
    parameter int unsigned EW   = PID_EW,
    parameter int unsigned KW   = PID_KW,
    parameter int unsigned OW   = PID_OW,
    parameter int unsigned FRAC = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clear,
    input  logic signed [EW-1:0] e,
    input  logic                 e_valid,
    output logic                 e_ready,
    input  logic [KW-1:0]        K_d,
    output logic signed [OW-1:0] d_contrib,
    output logic                 d_valid,
    output logic                 d_sat
);

    localparam int unsigned DW = EW + 1;
    localparam int unsigned AW = EW + 1 + KW;

    pid_state_e           state_q, state_d;
    logic signed [EW-1:0] e_prior_q, e_prior_d;
    logic                 primed_q, primed_d;
    logic signed [OW-1:0] d_contrib_q, d_contrib_d;
    logic                 d_sat_q, d_sat_d;
    logic                 d_valid_q, d_valid_d;

    logic signed [DW-1:0] diff_c;
    logic signed [AW-1:0] prod_c;
    logic signed [63:0]   scaled_c;
    logic signed [63:0]   clamped_c;
    logic                 clamp_hit_c;
    logic                 mul_start_c;
    logic                 mul_last_c;

    // Difference is zero until a previous sample exists (kick suppression).
    assign diff_c  = primed_q ? (DW'(e) - DW'(e_prior_q)) : '0;
    assign e_ready = ena && (state_q == IDLE) && !clear;

    seq_shift_add_mul #(
        .AW (DW),
        .BW (KW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (ena),
        .abort_i (clear),
        .start_i (mul_start_c),
        .a_i     (diff_c),
        .b_i     (K_d),
        .acc_o   (prod_c),
        .last_c  (mul_last_c)
    );

    // Fixed-point rescale and clamp of the finished product.
    always_comb begin
        clamp_hit_c = 1'b0;
        scaled_c    = 64'(prod_c) >>> FRAC;
        clamped_c   = sat_clamp(scaled_c, OW, clamp_hit_c);
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        e_prior_d   = e_prior_q;
        primed_d    = primed_q;
        d_contrib_d = d_contrib_q;
        d_sat_d     = d_sat_q;
        d_valid_d   = 1'b0;
        mul_start_c = 1'b0;
        if (ena) begin
            if (clear) begin
                state_d   = IDLE;
                primed_d  = 1'b0;
                e_prior_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (e_valid) begin
                            mul_start_c = 1'b1;
                            e_prior_d   = e;
                            primed_d    = 1'b1;
                            state_d     = MUL;
                        end
                    end
                    MUL: begin
                        if (mul_last_c) begin
                            state_d = SAT;
                        end
                    end
                    SAT: begin
                        d_contrib_d = OW'(clamped_c);
                        d_sat_d     = clamp_hit_c;
                        d_valid_d   = 1'b1;
                        state_d     = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State and output registers; d_valid drops on any edge where it is not re-issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            e_prior_q   <= '0;
            primed_q    <= 1'b0;
            d_contrib_q <= '0;
            d_sat_q     <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_prior_q   <= e_prior_d;
            primed_q    <= primed_d;
            d_contrib_q <= d_contrib_d;
            d_sat_q     <= d_sat_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign d_contrib = d_contrib_q;
    assign d_sat     = d_sat_q;
    assign d_valid   = d_valid_q;

endmodule

// File: tb/tb_pid_derivative_seq.sv
// Directed bench for pid_derivative_seq; a FRAC=2 instance shares the stimulus.
module tb_pid_derivative_seq;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              clear;
    logic signed [7:0] e;
    logic              e_valid;
    logic [5:0]        K_d;
    logic              e_ready,   e_ready1;
    logic signed [7:0] d_contrib, d_contrib1;
    logic              d_valid,   d_valid1;
    logic              d_sat,     d_sat1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pid_derivative_seq #(.EW(8), .KW(6), .OW(8), .FRAC(0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .e(e),
        .e_valid(e_valid), .e_ready(e_ready), .K_d(K_d),
        .d_contrib(d_contrib), .d_valid(d_valid), .d_sat(d_sat)
    );

    pid_derivative_seq #(.EW(8), .KW(6), .OW(8), .FRAC(2)) dut_frac (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .e(e),
        .e_valid(e_valid), .e_ready(e_ready1), .K_d(K_d),
        .d_contrib(d_contrib1), .d_valid(d_valid1), .d_sat(d_sat1)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Counts edges until d_valid is seen (bounded).
    task automatic wait_dv(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!d_valid && n < 40);
    endtask

    // Counts d_valid pulses over a number of edges.
    task automatic count_dv(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (d_valid) pulses++;
        end
    endtask

    // Present one sample, check latency, value, flag and single-cycle pulse.
    task automatic send(input string tag, input logic signed [7:0] ev, input logic [5:0] kv,
                        input int exp_v, input int exp_s);
        int n;
        @(negedge clk);
        e = ev;
        K_d = kv;
        e_valid = 1'b1;
        chk({tag, " ready"}, int'(e_ready), 1);
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        e = 8'sd0;
        wait_dv(n);
        chk({tag, " latency"}, n, 7);
        chk({tag, " value"}, int'(d_contrib), exp_v);
        chk({tag, " sat"}, int'(d_sat), exp_s);
        @(posedge clk);
        #1;
        chk({tag, " pulse_width"}, int'(d_valid), 0);
    endtask

    initial begin
        int n;
        int p;
        rst_n = 1'b0;
        ena = 1'b1;
        clear = 1'b0;
        e = 8'sd0;
        e_valid = 1'b0;
        K_d = 6'd0;

        // Reset state
        #22 rst_n = 1'b1;
        @(negedge clk);
        chk("rst d_contrib", int'(d_contrib), 0);
        chk("rst d_valid", int'(d_valid), 0);
        chk("rst d_sat", int'(d_sat), 0);
        chk("rst e_ready", int'(e_ready), 1);

        // Basic derivative with kick suppression
        send("first10", 8'sd10, 6'd3, 0, 0);
        send("e15k3", 8'sd15, 6'd3, 15, 0);
        send("e5k2", 8'sd5, 6'd2, -20, 0);

        // Clear at idle with a sample offered: not accepted
        @(negedge clk);
        clear = 1'b1;
        e_valid = 1'b1;
        e = 8'sd40;
        K_d = 6'd1;
        #1 chk("clear e_ready", int'(e_ready), 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        e_valid = 1'b0;
        count_dv(10, p);
        chk("clear no accept", p, 0);

        send("clr first10", 8'sd10, 6'd3, 0, 0);
        send("clr e15", 8'sd15, 6'd3, 15, 0);

        // Clear mid-multiply aborts the result
        @(negedge clk);
        e = 8'sd20;
        K_d = 6'd3;
        e_valid = 1'b1;
        @(posedge clk);
        #1 e_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        count_dv(12, p);
        chk("midclr no d_valid", p, 0);
        chk("midclr hold value", int'(d_contrib), 15);
        chk("midclr hold sat", int'(d_sat), 0);
        chk("midclr e_ready", int'(e_ready), 1);
        send("unprimed40", 8'sd40, 6'd1, 0, 0);
        send("e41", 8'sd41, 6'd1, 1, 0);

        // Zero gain
        send("k0", 8'sd50, 6'd0, 0, 0);

        // ena low for 5 cycles at cnt=2, e_valid held high throughout
        @(negedge clk);
        e = 8'sd60;
        K_d = 6'd1;
        e_valid = 1'b1;
        @(posedge clk);
        #1 e = 8'sd99;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ena0 e_ready", int'(e_ready), 0);
            chk("ena0 d_valid", int'(d_valid), 0);
            @(negedge clk);
        end
        ena = 1'b1;
        wait_dv(n);
        e_valid = 1'b0;
        chk("ena stall latency", n, 5);
        chk("ena stall value", int'(d_contrib), 10);
        count_dv(10, p);
        chk("held valid no extra", p, 0);
        send("after stall e61", 8'sd61, 6'd1, 1, 0);

        // Saturation both directions
        send("sat neg", -8'sd100, 6'd63, -128, 1);
        send("sat pos", 8'sd100, 6'd63, 127, 1);
        send("sat neg2", -8'sd100, 6'd63, -128, 1);

        // Async reset mid-multiply
        @(negedge clk);
        e = 8'sd30;
        K_d = 6'd5;
        e_valid = 1'b1;
        @(posedge clk);
        #1 e_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst d_contrib", int'(d_contrib), 0);
        chk("midrst d_sat", int'(d_sat), 0);
        chk("midrst d_valid", int'(d_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("postrst e_ready", int'(e_ready), 1);
        count_dv(10, p);
        chk("postrst no d_valid", p, 0);
        send("postrst first", 8'sd5, 6'd1, 0, 0);
        send("postrst e7", 8'sd7, 6'd1, 2, 0);

        // Fractional scaling (second instance has FRAC=2)
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        send("frac first0", 8'sd0, 6'd5, 0, 0);
        chk("frac1 first0", int'(d_contrib1), 0);
        send("frac e7", 8'sd7, 6'd5, 35, 0);
        chk("frac1 e7", int'(d_contrib1), 8);
        chk("frac1 e7 sat", int'(d_sat1), 0);
        send("frac e0", 8'sd0, 6'd5, -35, 0);
        chk("frac1 e0", int'(d_contrib1), -9);
        chk("frac1 ready", int'(e_ready1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
